pulse_stretcher: RTL

Converts a single-cycle trigger pulse (as produced by the design's edge/one-shot stages) back into a level held high for a programmable number of cycles. It is followed by a programmable minimum low (gap) time, with optional retriggering. Sits on the consumer side of trigger strobes, driving downstream enables, LEDs and timed control lines that need a held level rather than a strobe. Triggers that cannot be honoured are counted in a saturating counter.

---
 rtl/pulse_stretcher_pkg.sv | 13 +
 rtl/pulse_stretcher_if.sv | 25 ++
 rtl/pulse_stretcher_sat_counter.sv | 19 +
 rtl/pulse_stretcher.sv | 76 +++++++
 4 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared state encodings and default widths for the pulse stretcher.
package pulse_stretcher_pkg;

    localparam int DEF_LEN_W    = 8;
    localparam int DEF_MISSED_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_stretcher_if.sv
// Trigger/config inputs and stretched-level outputs of the pulse stretcher.
interface pulse_stretcher_if #(
    parameter int LEN_W    = 8,
    parameter int MISSED_W = 8
);
    logic                Shot;
    logic [LEN_W-1:0]    Length;
    logic [LEN_W-1:0]    Gap;
    logic                Retrigger;
    logic                Clear_Missed;
    logic                Level;
    logic                Busy;
    logic                Done;
    logic [MISSED_W-1:0] Missed;

    modport master (
        output Shot, Length, Gap, Retrigger, Clear_Missed,
        input  Level, Busy, Done, Missed
    );

    modport slave (
        input  Shot, Length, Gap, Retrigger, Clear_Missed,
        output Level, Busy, Done, Missed
    );
endinterface

// File: rtl/pulse_stretcher_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats a simultaneous increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/pulse_stretcher.sv
// Stretches a one-cycle trigger into a programmable-length level followed by a minimum low gap.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int LEN_W    = DEF_LEN_W,
    parameter int MISSED_W = DEF_MISSED_W
) (
    input  logic                clk,
    input  logic                reset,
    pulse_stretcher_if.slave    bus
);
    state_t           state;
    logic [LEN_W-1:0] cnt;
    logic             len_ok;
    logic             reload;
    logic             missed_inc;

    assign len_ok = (bus.Length != '0);
    assign reload = (state == ST_HIGH) && bus.Retrigger && bus.Shot && len_ok;

    // A Shot is rejected in GAP, and in HIGH unless it can legally restart the stretch.
    assign missed_inc = bus.Shot &&
                        ((state == ST_GAP) ||
                         ((state == ST_HIGH) && !(bus.Retrigger && len_ok)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.Shot && len_ok) begin
                        state <= ST_HIGH;
                        cnt   <= bus.Length - LEN_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (reload) begin
                        cnt <= bus.Length - LEN_W'(1);
                    end else if (cnt != '0) begin
                        cnt <= cnt - LEN_W'(1);
                    end else if (bus.Gap != '0) begin
                        state <= ST_GAP;
                        cnt   <= bus.Gap - LEN_W'(1);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - LEN_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.Level = (state == ST_HIGH);
    assign bus.Busy  = (state != ST_IDLE);
    assign bus.Done  = (state == ST_HIGH) && (cnt == '0) && !reload;

    sat_counter #(.W(MISSED_W)) u_missed (
        .clk   (clk),
        .reset (reset),
        .inc   (missed_inc),
        .clr   (bus.Clear_Missed),
        .count (bus.Missed)
    );
endmodule
